// File: rtl/reset_pulse_monitor_pkg.sv
// Shared definitions for the reset pulse monitor.
// Holds the FSM state encoding (2-bit), the default counter width and pulse
// thresholds, and a saturating increment helper for the event counter.
package reset_pulse_monitor_pkg;

    localparam int          CNT_W_DEF     = 25;
    localparam logic [24:0] MIN_PULSE_DEF = 25'd4;
    localparam logic [24:0] MAX_PULSE_DEF = 25'd21_900_000;
    localparam int          EVT_W         = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOW_QUAL = 2'd1,
        LOW      = 2'd2,
        STUCK    = 2'd3
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
        return (v == {EVT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reset_pulse_monitor_if.sv
// Signal bundle between the monitored reset line / its consumer and the
// reset pulse monitor.
//   line_n      monitored active-low reset line (async to clk)
//   clear       sync request to zero event_count
//   in_reset    level: qualified low pulse in progress
//   pulse_valid 1-cycle strobe: qualified pulse ended
//   pulse_len   length of the last qualified pulse, held between strobes
//   glitch      1-cycle strobe: low pulse shorter than the minimum seen
//   stuck       level: current pulse reached the stuck threshold
//   event_count qualified pulses seen, saturating
//   state       debug view of the monitor FSM state
// Handshake: there is no back-pressure. pulse_valid and glitch are single
// cycle strobes; a consumer must sample them on the cycle they are high.
// pulse_len is stable from the pulse_valid cycle until the next pulse_valid.
interface reset_pulse_monitor_if #(
    parameter int CNT_W = 25
);
    import reset_pulse_monitor_pkg::*;

    logic              line_n;
    logic              clear;
    logic              in_reset;
    logic              pulse_valid;
    logic [CNT_W-1:0]  pulse_len;
    logic              glitch;
    logic              stuck;
    logic [EVT_W-1:0]  event_count;
    state_t            state;

    modport master (
        output line_n, clear,
        input  in_reset, pulse_valid, pulse_len, glitch, stuck, event_count, state
    );

    modport slave (
        input  line_n, clear,
        output in_reset, pulse_valid, pulse_len, glitch, stuck, event_count, state
    );

endinterface

// File: rtl/reset_pulse_monitor_sync_ff_chain.sv
// sync_ff_chain: multi-flop synchronizer for a single async input.
// The chain presets to 1 on reset so an active-low input reads as released
// until real samples have propagated through.
//   clk    sampling clock
//   rst_n  async active-low reset (presets chain to 1)
//   d      asynchronous input
//   q      synchronized output, STAGES cycles behind d
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_pulse_monitor.sv
// reset_pulse_monitor: receive side of the target reset line.
// Synchronizes line_n, rejects low pulses shorter than MIN_PULSE, measures
// qualified low pulses in clk cycles, flags pulses reaching MAX_PULSE as
// stuck and counts qualified pulses.
//   clk    system clock
//   rst_n  async active-low reset
//   bus    slave side of reset_pulse_monitor_if (line_n/clear in, results out)
module reset_pulse_monitor
    import reset_pulse_monitor_pkg::*;
#(
    parameter int               SYNC_STAGES = 2,
    parameter int               CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] MIN_PULSE   = CNT_W'(MIN_PULSE_DEF),
    parameter logic [CNT_W-1:0] MAX_PULSE   = CNT_W'(MAX_PULSE_DEF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reset_pulse_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic s;

    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.line_n),
        .q     (s)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             pv_q, pv_d;
    logic             glitch_q, glitch_d;
    logic             in_reset_q, stuck_q;
    logic             inc;
    logic [EVT_W-1:0] evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            pv_q       <= 1'b0;
            glitch_q   <= 1'b0;
            in_reset_q <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            pv_q       <= pv_d;
            glitch_q   <= glitch_d;
            // Registered decode of the next state, so in_reset drops on the
            // same cycle pulse_valid rises.
            in_reset_q <= (state_d == LOW) || (state_d == STUCK);
            stuck_q    <= (state_d == STUCK);
        end
    end

    // cnt holds the number of consecutive low samples seen so far.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        pv_d     = 1'b0;
        glitch_d = 1'b0;
        inc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s) begin
                    cnt_d   = ONE;
                    state_d = (MIN_PULSE == ONE) ? LOW : LOW_QUAL;
                end
            end
            LOW_QUAL: begin
                if (s) begin
                    glitch_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == MIN_PULSE - ONE) state_d = LOW;
                end
            end
            LOW: begin
                if (s) begin
                    pv_d    = 1'b1;
                    len_d   = cnt_q;
                    inc     = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    if (cnt_q < MAX_PULSE) cnt_d = cnt_q + ONE;
                    if (cnt_q == MAX_PULSE - ONE) state_d = STUCK;
                end
            end
            STUCK: begin
                if (s) begin
                    pv_d    = 1'b1;
                    len_d   = MAX_PULSE;
                    inc     = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else if (bus.clear) begin
            evt_q <= '0;
        end else if (inc) begin
            evt_q <= sat_inc(evt_q);
        end
    end

    assign bus.in_reset    = in_reset_q;
    assign bus.pulse_valid = pv_q;
    assign bus.pulse_len   = len_q;
    assign bus.glitch      = glitch_q;
    assign bus.stuck       = stuck_q;
    assign bus.event_count = evt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_reset_pulse_monitor.sv
module tb_reset_pulse_monitor;
    import reset_pulse_monitor_pkg::*;

    localparam int               CNT_W = 25;
    localparam logic [CNT_W-1:0] MIN_P = 25'd4;
    localparam logic [CNT_W-1:0] MAX_P = 25'd100;

    logic clk;
    logic rst_n;

    int vectors     = 0;
    int miscompares = 0;

    int glitch_seen   = 0;
    int pv_seen       = 0;
    int in_reset_seen = 0;

    reset_pulse_monitor_if #(.CNT_W(CNT_W)) bus ();

    reset_pulse_monitor #(
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W),
        .MIN_PULSE   (MIN_P),
        .MAX_PULSE   (MAX_P)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe / level observers, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.glitch)      glitch_seen++;
        if (bus.pulse_valid) pv_seen++;
        if (bus.in_reset)    in_reset_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int g0, p0, r0;

    initial begin
        // 1. reset
        rst_n       = 1'b0;
        bus.line_n  = 1'b1;
        bus.clear   = 1'b0;
        tick(5);
        check("rst_in_reset",    32'(bus.in_reset), 0);
        check("rst_pulse_valid", 32'(bus.pulse_valid), 0);
        check("rst_pulse_len",   32'(bus.pulse_len), 0);
        check("rst_glitch",      32'(bus.glitch), 0);
        check("rst_stuck",       32'(bus.stuck), 0);
        check("rst_event_count", 32'(bus.event_count), 0);
        check("rst_state",       32'(bus.state), 32'(IDLE));
        rst_n = 1'b1;
        tick(4);

        // 2. 3-cycle low: glitch, not a pulse
        g0 = glitch_seen; p0 = pv_seen; r0 = in_reset_seen;
        bus.line_n = 1'b0;
        tick(3);
        bus.line_n = 1'b1;
        tick(3);
        check("glitch_strobe", 32'(bus.glitch), 1);
        tick(5);
        check("glitch_count",   32'(glitch_seen - g0), 1);
        check("glitch_no_pv",   32'(pv_seen - p0), 0);
        check("glitch_no_inr",  32'(in_reset_seen - r0), 0);
        check("glitch_evt",     32'(bus.event_count), 0);

        // 3. 50-cycle low pulse
        g0 = glitch_seen; p0 = pv_seen;
        bus.line_n = 1'b0;
        tick(5);
        check("p50_inr_before", 32'(bus.in_reset), 0);
        tick(1);
        check("p50_inr_rise",   32'(bus.in_reset), 1);
        tick(44);
        bus.line_n = 1'b1;
        tick(2);
        check("p50_inr_hold",   32'(bus.in_reset), 1);
        tick(1);
        check("p50_pv",         32'(bus.pulse_valid), 1);
        check("p50_len",        32'(bus.pulse_len), 50);
        check("p50_inr_fall",   32'(bus.in_reset), 0);
        check("p50_evt",        32'(bus.event_count), 1);
        tick(1);
        check("p50_pv_1cyc",    32'(bus.pulse_valid), 0);
        check("p50_len_held",   32'(bus.pulse_len), 50);
        check("p50_no_glitch",  32'(glitch_seen - g0), 0);
        check("p50_pv_count",   32'(pv_seen - p0), 1);
        tick(4);

        // 4. 150-cycle low: stuck at 100 samples
        bus.line_n = 1'b0;
        tick(101);
        check("stk_before",     32'(bus.stuck), 0);
        tick(1);
        check("stk_rise",       32'(bus.stuck), 1);
        check("stk_inr",        32'(bus.in_reset), 1);
        check("stk_state",      32'(bus.state), 32'(STUCK));
        tick(48);
        bus.line_n = 1'b1;
        tick(3);
        check("stk_pv",         32'(bus.pulse_valid), 1);
        check("stk_len",        32'(bus.pulse_len), 100);
        check("stk_clear",      32'(bus.stuck), 0);
        check("stk_evt",        32'(bus.event_count), 2);
        tick(4);

        // 5. resetter stand-in: PULSE_CYCLES=20 holds line low 21 cycles
        g0 = glitch_seen;
        bus.line_n = 1'b0;
        tick(21);
        bus.line_n = 1'b1;
        tick(3);
        check("lb_pv",          32'(bus.pulse_valid), 1);
        check("lb_len",         32'(bus.pulse_len), 21);
        check("lb_evt",         32'(bus.event_count), 3);
        check("lb_no_glitch",   32'(glitch_seen - g0), 0);
        tick(4);

        // 6a. reset mid-pulse clears outputs immediately
        bus.line_n = 1'b0;
        tick(10);
        check("mid_inr_pre",    32'(bus.in_reset), 1);
        rst_n = 1'b0;
        #1;
        check("mid_inr",        32'(bus.in_reset), 0);
        check("mid_evt",        32'(bus.event_count), 0);
        check("mid_len",        32'(bus.pulse_len), 0);
        check("mid_state",      32'(bus.state), 32'(IDLE));
        bus.line_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(4);

        // 6b. clear coincident with pulse_valid
        bus.line_n = 1'b0;
        tick(10);
        bus.line_n = 1'b1;
        tick(3);
        check("clr_pre_len",    32'(bus.pulse_len), 10);
        check("clr_pre_evt",    32'(bus.event_count), 1);
        tick(2);
        bus.line_n = 1'b0;
        tick(12);
        bus.line_n = 1'b1;
        tick(2);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        check("clr_pv",         32'(bus.pulse_valid), 1);
        check("clr_len",        32'(bus.pulse_len), 12);
        check("clr_evt",        32'(bus.event_count), 0);
        tick(2);
        check("clr_evt_hold",   32'(bus.event_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
